pot_scan_ctrl: RTL and testbench

Round-robin scanner that sequences the external A2D converter across the six equalizer slide pots and holds the latest reading of each one in a register. It owns the start/complete handshake with the A2D SPI interface and drives the POT_LP, POT_B1, POT_B2, POT_B3, POT_HP and POT_VOL buses into the digital core, where they set band gains and volume. It also reports scan completion, first-scan validity and A2D timeouts.

---
 rtl/pot_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pot_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl
//   Round-robin scanner for the six equalizer slide pots. It sequences the
//   external A2D through a fixed channel order, keeps the latest reading of
//   each pot in a register, and flags scan completion, first-scan validity
//   and lost conversions.
//
// Parameters
//   GAP_CYCLES : idle cycles between a conversion completing and the next start (>= 1)
//   TIMEOUT    : cycles allowed in WAIT for cnv_cmplt before the conversion is retried
//
// Ports
//   clk, rst_n          : system clock, asynchronous active-low reset
//   en                  : scan enable, sampled only between conversions
//   cnv_cmplt, res      : A2D completion pulse and the 12-bit result valid with it
//   strt_cnv, chnnl     : one-cycle conversion start and the channel select
//   POT_LP..POT_VOL     : latest reading of each pot
//   scan_done           : one-cycle pulse after each full six-channel scan
//   pots_valid          : sticky, set after the first complete scan
//   a2d_err             : sticky, set on any conversion timeout
module pot_scan_ctrl #(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] POT_VOL,
  output logic        scan_done,
  output logic        pots_valid,
  output logic        a2d_err
);

  // Counters run 0..N-1, so clog2(N) bits suffice; keep at least one bit.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    LAST_SLOT = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GAP
  } state_t;

  // Slot order is LP, B1, B2, B3, HP, VOL; the board wiring scrambles the
  // A2D channel numbers.
  function automatic logic [2:0] slot_chnnl(input logic [2:0] s);
    logic [2:0] c;
    case (s)
      3'd0:    c = 3'd1;
      3'd1:    c = 3'd0;
      3'd2:    c = 3'd4;
      3'd3:    c = 3'd2;
      3'd4:    c = 3'd3;
      3'd5:    c = 3'd7;
      default: c = 3'd1;
    endcase
    return c;
  endfunction

  state_t          state_reg, state_next;
  logic [2:0]      slot_reg, slot_next;
  logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;
  logic            strt_reg, strt_next;
  logic [2:0]      chnnl_reg, chnnl_next;
  logic [11:0]     pot_reg [6];
  logic [11:0]     pot_next [6];
  logic            scan_done_reg, scan_done_next;
  logic            pots_valid_reg, pots_valid_next;
  logic            a2d_err_reg, a2d_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      slot_reg       <= 3'd0;
      gap_cnt_reg    <= '0;
      to_cnt_reg     <= '0;
      strt_reg       <= 1'b0;
      chnnl_reg      <= 3'd1;
      scan_done_reg  <= 1'b0;
      pots_valid_reg <= 1'b0;
      a2d_err_reg    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        pot_reg[i] <= 12'h000;
      end
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      gap_cnt_reg    <= gap_cnt_next;
      to_cnt_reg     <= to_cnt_next;
      strt_reg       <= strt_next;
      chnnl_reg      <= chnnl_next;
      scan_done_reg  <= scan_done_next;
      pots_valid_reg <= pots_valid_next;
      a2d_err_reg    <= a2d_err_next;
      for (int i = 0; i < 6; i++) begin
        pot_reg[i] <= pot_next[i];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    slot_next       = slot_reg;
    gap_cnt_next    = gap_cnt_reg;
    to_cnt_next     = to_cnt_reg;
    strt_next       = 1'b0;
    chnnl_next      = chnnl_reg;
    scan_done_next  = 1'b0;
    pots_valid_next = pots_valid_reg;
    a2d_err_next    = a2d_err_reg;
    for (int i = 0; i < 6; i++) begin
      pot_next[i] = pot_reg[i];
    end

    case (state_reg)
      ST_IDLE: begin
        if (en) begin
          strt_next   = 1'b1;
          chnnl_next  = slot_chnnl(slot_reg);
          to_cnt_next = '0;
          state_next  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Completion is checked first so a reply landing on the expiry
        // cycle is still captured without an error.
        if (cnv_cmplt) begin
          for (int i = 0; i < 6; i++) begin
            if (slot_reg == 3'(i)) begin
              pot_next[i] = res;
            end
          end
          to_cnt_next  = '0;
          gap_cnt_next = '0;
          state_next   = ST_GAP;
        end else if (to_cnt_reg == TO_LAST) begin
          // Lost conversion: flag it and retry the same slot.
          a2d_err_next = 1'b1;
          to_cnt_next  = '0;
          state_next   = ST_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = ST_IDLE;
          if (slot_reg == LAST_SLOT) begin
            slot_next       = 3'd0;
            scan_done_next  = 1'b1;
            pots_valid_next = 1'b1;
          end else begin
            slot_next = slot_reg + 3'd1;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign strt_cnv   = strt_reg;
  assign chnnl      = chnnl_reg;
  assign scan_done  = scan_done_reg;
  assign pots_valid = pots_valid_reg;
  assign a2d_err    = a2d_err_reg;
  assign POT_LP     = pot_reg[0];
  assign POT_B1     = pot_reg[1];
  assign POT_B2     = pot_reg[2];
  assign POT_B3     = pot_reg[3];
  assign POT_HP     = pot_reg[4];
  assign POT_VOL    = pot_reg[5];

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// tb_pot_scan_ctrl
//   Directed bench for pot_scan_ctrl with GAP_CYCLES=16 and TIMEOUT=64.
//   The bench plays the A2D: it watches strt_cnv and answers with cnv_cmplt
//   and a hand-chosen result after a chosen delay (or not at all).
module tb_pot_scan_ctrl;

  localparam int GAP = 16;
  localparam int TO  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = 12'h000;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL;
  logic        scan_done, pots_valid, a2d_err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   sd_cnt = 0;
  logic sd_pv = 1'b0;

  logic [2:0] exp_ch [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  pot_scan_ctrl #(
    .GAP_CYCLES(GAP),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .cnv_cmplt(cnv_cmplt),
    .res(res),
    .strt_cnv(strt_cnv),
    .chnnl(chnnl),
    .POT_LP(POT_LP),
    .POT_B1(POT_B1),
    .POT_B2(POT_B2),
    .POT_B3(POT_B3),
    .POT_HP(POT_HP),
    .POT_VOL(POT_VOL),
    .scan_done(scan_done),
    .pots_valid(pots_valid),
    .a2d_err(a2d_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count scan_done pulses and note pots_valid in the same cycle.
  always @(negedge clk) begin
    if (scan_done) begin
      sd_cnt <= sd_cnt + 1;
      sd_pv  <= pots_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a strt_cnv pulse, sampling on the falling edge.
  task automatic wait_strt(output logic [2:0] ch, output int t);
    logic seen;
    seen = 1'b0;
    ch = 3'd0;
    t = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (strt_cnv) begin
        seen = 1'b1;
        ch = chnnl;
        t = cyc;
      end
    end
    check("strt_seen", {31'b0, seen}, 32'd1);
  endtask

  // Called at the falling edge of the strt_cnv cycle; cnv_cmplt is then
  // high during the cycle dly cycles later.
  task automatic reply(input int dly, input logic [11:0] val);
    repeat (dly) @(negedge clk);
    cnv_cmplt = 1'b1;
    res = val;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    res = 12'h000;
    $display("conv: chnnl=%0d res=%h delay=%0d", chnnl, val, dly);
  endtask

  initial begin
    logic [2:0] ch;
    int t, tprev, t0, tdrop, n;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_strt", {31'b0, strt_cnv}, 32'd0);
    check("rst_chnnl", {29'b0, chnnl}, 32'd1);
    check("rst_lp", {20'b0, POT_LP}, 32'h0);
    check("rst_vol", {20'b0, POT_VOL}, 32'h0);
    check("rst_done", {31'b0, scan_done}, 32'd0);
    check("rst_valid", {31'b0, pots_valid}, 32'd0);
    check("rst_err", {31'b0, a2d_err}, 32'd0);

    // Release with en=1: start in the very next cycle
    rst_n = 1'b1;
    en = 1'b1;
    t0 = cyc;
    wait_strt(ch, t);
    check("first_lat", t - t0, 32'd1);
    tprev = t;

    // First scan, res = 0x100 + chnnl
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        wait_strt(ch, t);
        check("spacing", t - tprev, 32'd38);
        tprev = t;
      end
      check("scan1_ch", {29'b0, ch}, {29'b0, exp_ch[i]});
      if (i == 5) begin
        check("valid_early", {31'b0, pots_valid}, 32'd0);
        check("done_early", sd_cnt, 32'd0);
      end
      if (i == 0) begin
        repeat (20) @(negedge clk);
        cnv_cmplt = 1'b1;
        res = 12'h101;
        check("cap_hold", {20'b0, POT_LP}, 32'h0);
        @(negedge clk);
        cnv_cmplt = 1'b0;
        res = 12'h000;
        $display("conv: chnnl=%0d res=101 delay=20", chnnl);
        check("cap_lat", {20'b0, POT_LP}, 32'h101);
      end else begin
        reply(20, 12'h100 + {9'b0, ch});
      end
    end

    // Second scan starts; first scan results visible
    wait_strt(ch, t);
    check("spacing_wrap", t - tprev, 32'd38);
    check("scan2_ch0", {29'b0, ch}, 32'd1);
    check("pot_lp", {20'b0, POT_LP}, 32'h101);
    check("pot_b1", {20'b0, POT_B1}, 32'h100);
    check("pot_b2", {20'b0, POT_B2}, 32'h104);
    check("pot_b3", {20'b0, POT_B3}, 32'h102);
    check("pot_hp", {20'b0, POT_HP}, 32'h103);
    check("pot_vol", {20'b0, POT_VOL}, 32'h107);
    check("done_once", sd_cnt, 32'd1);
    check("done_valid", {31'b0, sd_pv}, 32'd1);
    check("valid_set", {31'b0, pots_valid}, 32'd1);
    reply(20, 12'h201);

    wait_strt(ch, t);
    check("scan2_ch1", {29'b0, ch}, 32'd0);
    reply(20, 12'h200);

    // Slot 2: drop the reply, expect timeout and retry
    wait_strt(ch, t);
    check("scan2_ch2", {29'b0, ch}, 32'd4);
    tdrop = t;
    repeat (TO - 1) @(negedge clk);
    check("err_early", {31'b0, a2d_err}, 32'd0);
    @(negedge clk);
    check("err_rise", {31'b0, a2d_err}, 32'd1);
    $display("conv: chnnl=4 dropped, timeout");
    wait_strt(ch, t);
    check("retry_lat", t - tdrop, 32'd65);
    check("retry_ch", {29'b0, ch}, 32'd4);
    check("to_b2_hold", {20'b0, POT_B2}, 32'h104);
    check("to_lp_hold", {20'b0, POT_LP}, 32'h201);
    check("to_b1_hold", {20'b0, POT_B1}, 32'h200);
    reply(20, 12'h204);
    check("retry_cap", {20'b0, POT_B2}, 32'h204);

    // Slot 3: drop en during WAIT, conversion still completes, then park
    wait_strt(ch, t);
    check("scan2_ch3", {29'b0, ch}, 32'd2);
    en = 1'b0;
    reply(20, 12'h202);
    check("b3_cap", {20'b0, POT_B3}, 32'h202);
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (strt_cnv) n++;
    end
    check("park_no_strt", n, 32'd0);

    // Spurious completion while parked
    cnv_cmplt = 1'b1;
    res = 12'hFFF;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    res = 12'h000;
    @(negedge clk);
    $display("conv: spurious res=fff while parked");
    check("spur_b3", {20'b0, POT_B3}, 32'h202);
    check("spur_hp", {20'b0, POT_HP}, 32'h103);
    check("spur_vol", {20'b0, POT_VOL}, 32'h107);
    check("spur_lp", {20'b0, POT_LP}, 32'h201);
    check("spur_strt", {31'b0, strt_cnv}, 32'd0);

    // Resume: slot already advanced to HP
    en = 1'b1;
    @(negedge clk);
    check("resume_strt", {31'b0, strt_cnv}, 32'd1);
    check("resume_ch", {29'b0, chnnl}, 32'd3);
    reply(20, 12'h203);
    check("hp_cap", {20'b0, POT_HP}, 32'h203);

    // Slot 5: reset in the middle of WAIT
    wait_strt(ch, t);
    check("scan2_ch5", {29'b0, ch}, 32'd7);
    repeat (10) @(negedge clk);
    check("pre_rst_valid", {31'b0, pots_valid}, 32'd1);
    check("pre_rst_err", {31'b0, a2d_err}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strt", {31'b0, strt_cnv}, 32'd0);
    check("arst_chnnl", {29'b0, chnnl}, 32'd1);
    check("arst_lp", {20'b0, POT_LP}, 32'h0);
    check("arst_hp", {20'b0, POT_HP}, 32'h0);
    check("arst_done", {31'b0, scan_done}, 32'd0);
    check("arst_valid", {31'b0, pots_valid}, 32'd0);
    check("arst_err", {31'b0, a2d_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    wait_strt(ch, t);
    check("restart_ch", {29'b0, ch}, 32'd1);

    // Reply lands on the timeout-expiry cycle: capture wins, no error
    reply(TO - 1, 12'h3A1);
    check("race_cap", {20'b0, POT_LP}, 32'h3A1);
    check("race_err0", {31'b0, a2d_err}, 32'd0);
    @(negedge clk);
    check("race_err1", {31'b0, a2d_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
